// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, one quotient bit per clock, valid/ready on both sides
// Optional signed mode is compiled in with `define DIV_SIGNED_EN.
`timescale 1ns/1ps
module seq_divider #(
  parameter int N     = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     dividend,
  input  logic [N-1:0]     divisor,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     quotient,
  output logic [N-1:0]     remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d, out_tag_q, out_tag_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d, dbz_q, dbz_d;
  logic [N-1:0]     quotient_q, quotient_d, remainder_q, remainder_d;

  logic [N:0]       shifted;
  logic             ge;
  logic [N-1:0]     rem_next, quo_next, cap_dvd, cap_dvs, fin_quo, fin_rem;
  logic             accept, finish, zero_div;

  assign accept   = (state_q == S_IDLE) && in_valid;
  assign finish   = (state_q == S_BUSY) && (cnt_q == '0);
  assign zero_div = (divisor == '0);

  // One restoring step: the partial remainder never exceeds N bits after subtraction.
  always_comb begin
    shifted  = {rem_q, dvd_q[cnt_q]};
    ge       = (shifted >= {1'b0, dvs_q});
    rem_next = ge ? (shifted[N-1:0] - dvs_q) : shifted[N-1:0];
    quo_next = {quo_q[N-2:0], ge};
  end

`ifdef DIV_SIGNED_EN
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  logic qneg_q, qneg_d, rneg_q, rneg_d, ovf_pend_q, ovf_pend_d, overflow_q, overflow_d;
  logic a_neg, b_neg;

  always_comb begin
    a_neg      = in_signed & dividend[N-1];
    b_neg      = in_signed & divisor[N-1];
    cap_dvd    = a_neg ? (~dividend + 1'b1) : dividend;
    cap_dvs    = b_neg ? (~divisor + 1'b1) : divisor;
    fin_quo    = qneg_q ? (~quo_next + 1'b1) : quo_next;
    fin_rem    = rneg_q ? (~rem_next + 1'b1) : rem_next;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    ovf_pend_d = ovf_pend_q;
    overflow_d = overflow_q;
    if (accept) begin
      qneg_d     = a_neg ^ b_neg;
      rneg_d     = a_neg;
      ovf_pend_d = in_signed && (dividend == MIN_VAL) && (&divisor);
      if (zero_div) overflow_d = 1'b0;
    end
    if (finish) overflow_d = ovf_pend_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      ovf_pend_q <= ovf_pend_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`else
  logic unused_in_signed;
  assign unused_in_signed = in_signed;
  assign cap_dvd  = dividend;
  assign cap_dvs  = divisor;
  assign fin_quo  = quo_next;
  assign fin_rem  = rem_next;
  assign overflow = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    tag_d       = tag_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    out_tag_d   = out_tag_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dvd_d      = cap_dvd;
          dvs_d      = cap_dvs;
          rem_d      = '0;
          quo_d      = '0;
          cnt_d      = CW'(N - 1);
          tag_d      = in_tag;
          in_ready_d = 1'b0;
          if (zero_div) begin
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            out_tag_d   = in_tag;
            dbz_d       = 1'b1;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        rem_d = rem_next;
        quo_d = quo_next;
        if (cnt_q == '0) begin
          state_d     = S_DONE;
          quotient_d  = fin_quo;
          remainder_d = fin_rem;
          out_tag_d   = tag_q;
          dbz_d       = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        // out_valid follows entry into DONE by one clock; results are already stable.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      tag_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      out_tag_q   <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      out_tag_q   <= out_tag_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign out_tag     = out_tag_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider with an arithmetic reference model
`timescale 1ns/1ps
module tb_seq_divider;
  localparam int N = 16;
  localparam int TAG_W = 4;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     dividend = '0;
  logic [N-1:0]     divisor = '0;
  logic             in_signed = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [N-1:0]     quotient, remainder;
  logic [TAG_W-1:0] out_tag;
  logic             div_by_zero, overflow;

  typedef struct {
    logic [N-1:0]     q;
    logic [N-1:0]     r;
    logic [TAG_W-1:0] tag;
    logic             dbz;
    logic             ovf;
    int               acc;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rnd_ready = 1'b0;

  seq_divider #(.N(N), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .out_tag(out_tag), .div_by_zero(div_by_zero),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Plain-arithmetic reference: unsigned / and %, or signed / and % (truncating) in signed mode.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic s, input logic [TAG_W-1:0] t);
    exp_t e;
    logic signed [N-1:0] sa, sbv;
    logic use_signed;
    use_signed = s & SIGNED_EN;
    sa = a;
    sbv = b;
    e.tag = t; e.dbz = 1'b0; e.ovf = 1'b0; e.acc = 0; e.lat = N + 1;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 1;
    end else if (use_signed && sa == -(2 ** (N - 1)) && sbv == -1) begin
      e.q = a; e.r = '0; e.ovf = 1'b1;
    end else if (use_signed) begin
      e.q = sa / sbv; e.r = sa % sbv;
    end else begin
      e.q = a / b; e.r = a % b;
    end
    return e;
  endfunction

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic s, input logic [TAG_W-1:0] t);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin fail_timeout("accept_wait"); return; end
    dividend = a; divisor = b; in_signed = s; in_tag = t; in_valid = 1'b1;
    e = model(a, b, s, t);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(in_ready && sb.size() == 0) && n < 300) begin
      @(posedge clk); #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    if (!(in_ready && sb.size() == 0)) fail_timeout("idle_wait");
  endtask

  // Monitor: latency on each rising out_valid, hold-stable during stalls, compare on retire.
  initial begin
    logic        prev_ov, prev_or;
    logic [63:0] prev_b, cur_b;
    exp_t        e;
    prev_ov = 1'b0; prev_or = 1'b0; prev_b = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 1'b0;
      end else begin
        cur_b = {26'd0, quotient, remainder, out_tag, div_by_zero, overflow};
        if (out_valid) begin
          chk("in_ready_low_while_valid", in_ready, 1'b0);
          if (!prev_ov) begin
            if (sb.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_output: got q=0x%0h tag=%0d expected no result", quotient, out_tag);
            end else begin
              chk("latency", cyc - sb[0].acc, sb[0].lat);
            end
          end else if (!prev_or) begin
            chk("stall_stable", cur_b, prev_b);
          end
          if (out_ready && sb.size() > 0) begin
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("out_tag", out_tag, e.tag);
            chk("div_by_zero", div_by_zero, e.dbz);
            chk("overflow", overflow, e.ovf);
          end
        end
        prev_ov = out_valid;
        prev_or = out_ready;
        prev_b = cur_b;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [N-1:0] a, b;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_flags", {div_by_zero, overflow}, 2'b00);
    rst = 1'b0;

    do_op(16'd100, 16'd7, 1'b0, 4'd3);   wait_idle();
    do_op(16'hFFFF, 16'd1, 1'b0, 4'd1);  wait_idle();
    do_op(16'd5, 16'd9, 1'b0, 4'd2);     wait_idle();
    do_op(16'd5, 16'd0, 1'b0, 4'd4);     wait_idle();
    do_op(16'd20, 16'd4, 1'b0, 4'd5);    wait_idle();

    // Consumer stall with ignored in_valid pulses.
    out_ready = 1'b0;
    do_op(16'd100, 16'd7, 1'b0, 4'd6);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    if (!out_valid) fail_timeout("stall_valid");
    repeat (6) begin
      dividend = 16'd1; divisor = 16'd1; in_tag = 4'd9; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_during_stall", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("retire_out_valid", out_valid, 1'b0);
    chk("retire_in_ready", in_ready, 1'b1);

    // Asynchronous reset in the middle of an operation.
    do_op(16'd100, 16'd7, 1'b0, 4'd7);
    repeat (7) @(posedge clk);
    #2;
    chk("busy_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_in_ready", in_ready, 1'b1);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(16'd81, 16'd9, 1'b0, 4'd8);    wait_idle();

`ifdef DIV_SIGNED_EN
    do_op(16'hFF9C, 16'h0007, 1'b1, 4'd10); wait_idle();
    do_op(16'h8000, 16'hFFFF, 1'b1, 4'd11); wait_idle();
    do_op(16'h0064, 16'hFFF9, 1'b1, 4'd12); wait_idle();
    do_op(16'hFF9C, 16'h0000, 1'b1, 4'd13); wait_idle();
`else
    do_op(16'hFF9C, 16'h0007, 1'b1, 4'd10); wait_idle();
`endif

    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 16'd1;
        2: b = a + 16'd1;
        3: b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      wait_idle();
      do_op(a, b, 1'($urandom_range(0, 1)), 4'($urandom));
    end
    rnd_ready = 1'b0;
    wait_idle();
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised multi-cycle restoring divider producing one quotient bit per clock.
- Valid/ready handshake on both the operand side and the result side.
- Carries a request tag through the block; flags divide-by-zero.
- Sits beside the ALU as the execution unit for the DIV/REM class of instructions.

Parameters:
- N, 16, operand/quotient/remainder width in bits (N >= 2)
- TAG_W, 4, width of the pass-through request tag (TAG_W >= 1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands
- dividend  in  N  dividend
- divisor  in  N  divisor
- in_signed  in  1  two's-complement mode request; ignored unless DIV_SIGNED_EN is defined
- in_tag  in  TAG_W  request tag
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- quotient  out  N  quotient
- remainder  out  N  remainder
- out_tag  out  TAG_W  tag captured with the operands
- div_by_zero  out  1  divisor was zero
- overflow  out  1  signed MIN / -1 case; constant 0 without DIV_SIGNED_EN

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - FSM returns to IDLE.
  - out_valid = 0, in_ready = 1.
  - quotient, remainder, out_tag, div_by_zero and overflow = 0.
  - Internal registers = 0.
- States IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
- IDLE:
  - On in_valid && in_ready, capture the operands and in_tag.
  - Load the partial remainder with 0 and the iteration counter with N-1.
  - Go to BUSY, or to DONE directly if divisor == 0.
- BUSY, each cycle:
  - Partial remainder R = {R[N-1:0], dividend bit[counter]}, held internally as N+1 bits.
  - If R >= divisor: R = R - divisor and the quotient bit is set to 1; otherwise the quotient bit is 0.
  - When counter == 0, go to DONE; otherwise decrement the counter.
- Latency:
  - Normal operation: out_valid rises N+1 clocks after the accepting edge (N BUSY cycles, then DONE).
  - Divide-by-zero: out_valid rises 1 clock after the accepting edge.
- Divide-by-zero result: quotient = all ones, remainder = dividend, div_by_zero = 1. The result is otherwise handled as a normal result.
- DONE:
  - out_valid = 1.
  - quotient, remainder, out_tag and the flags are held stable until out_ready is sampled high.
  - On out_valid && out_ready, go to IDLE; in_ready rises the following cycle (no overlap of accept and retire).
- in_valid while not in_ready: ignored; the operands are not captured.
- Result outputs are registered and change only when entering DONE.
- Reset mid-operation: the result is discarded and out_valid = 0 immediately (asynchronous). No partial result is ever presented.
- Unsigned arithmetic: dividend == quotient*divisor + remainder, with remainder < divisor, for every nonzero divisor.
- Edge cases:
  - divisor > dividend: quotient = 0, remainder = dividend.
  - divisor == 1: quotient = dividend, remainder = 0.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- When defined and in_signed = 1 at capture:
  - Operand magnitudes are divided unsigned.
  - The quotient is negated when the operand signs differ (truncation toward zero).
  - The remainder takes the sign of the dividend.
  - Sign correction is applied on the BUSY->DONE transition, so latency is unchanged.
  - Signed divide-by-zero: quotient = all ones (-1), remainder = dividend.
  - MIN / -1: quotient = MIN, remainder = 0, overflow = 1.
- When not defined:
  - in_signed is ignored and the block is unsigned only.
  - overflow is tied to 0.
  - No sign-handling logic is synthesised.

Test Plan:
- N=16, dividend=100, divisor=7, tag=3, out_ready=1 -> out_valid exactly 17 clocks after accept; quotient=14, remainder=2, out_tag=3, flags 0.
- dividend=0xFFFF, divisor=0x0001, then dividend=5, divisor=9 -> first result q=0xFFFF r=0; second result q=0 r=5; in_ready low throughout each operation.
- dividend=5, divisor=0 -> out_valid 1 clock after accept; q=0xFFFF, r=5, div_by_zero=1; the next op (20/4) gives q=5 r=0 with div_by_zero=0.
- 100/7 with out_ready held 0 for 6 cycles after out_valid -> outputs stable, in_ready=0, in_valid pulses ignored; retire on out_ready=1, in_ready=1 on the next clock.
- Assert rst 8 clocks into 100/7 -> out_valid=0 and in_ready=1 without waiting for a clock edge; after release, 81/9 gives q=9 r=0 with no stale data.
- DIV_SIGNED_EN defined, in_signed=1:
  - -100/7 (0xFF9C/0x0007) -> q=0xFFF2, r=0xFFFE.
  - 0x8000/0xFFFF -> q=0x8000, r=0, overflow=1.
